// File: rtl/pe_sequencer.sv
// Phase sequencer for the PE-array data-path mux: walks sel through load,
// shift and write-back phases with per-phase length counting, then pulses done.
module pe_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] ld_len,
  input  logic [CNT_W-1:0] sh_len,
  input  logic [CNT_W-1:0] wb_len,
  input  logic             abort,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic             sh_en,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] ld_len_q;
  logic [CNT_W-1:0] sh_len_q;
  logic [CNT_W-1:0] wb_len_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic [CNT_W-1:0] phase_len_d;
  logic             xfer_d;
  logic             cnt_last_d;
  state_e           start_next_d;
  state_e           phase_next_d;

  // First phase, in LOAD->SHIFT->WB order, whose length is nonzero.
  function automatic state_e first_phase(input logic [CNT_W-1:0] l,
                                         input logic [CNT_W-1:0] s,
                                         input logic [CNT_W-1:0] w);
    state_e r;
    if (l != '0)      r = S_LOAD;
    else if (s != '0) r = S_SHIFT;
    else if (w != '0) r = S_WB;
    else              r = S_DONE;
    return r;
  endfunction

  // Per-phase length, transfer qualifier and follow-on phase.
  always_comb begin
    phase_len_d  = '0;
    xfer_d       = 1'b0;
    phase_next_d = S_DONE;
    unique case (state_q)
      S_LOAD: begin
        phase_len_d  = ld_len_q;
        xfer_d       = ld_valid;
        phase_next_d = first_phase('0, sh_len_q, wb_len_q);
      end
      S_SHIFT: begin
        phase_len_d  = sh_len_q;
        xfer_d       = 1'b1;
        phase_next_d = first_phase('0, '0, wb_len_q);
      end
      S_WB: begin
        phase_len_d  = wb_len_q;
        xfer_d       = wb_ready;
        phase_next_d = S_DONE;
      end
      default: ;
    endcase
  end

  // Compare against length-1 so a full-scale length never needs cnt to wrap.
  assign cnt_last_d   = (cnt_q == (phase_len_d - CNT_W'(1)));
  assign start_next_d = first_phase(ld_len, sh_len, wb_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ld_len_q <= '0;
      sh_len_q <= '0;
      wb_len_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              ld_len_q <= ld_len;
              sh_len_q <= sh_len;
              wb_len_q <= wb_len;
              cnt_q    <= '0;
              state_q  <= start_next_d;
              done_q   <= (start_next_d == S_DONE);
            end
          end
          S_LOAD, S_SHIFT, S_WB: begin
            if (xfer_d) begin
              if (cnt_last_d) begin
                cnt_q   <= '0;
                state_q <= phase_next_d;
                done_q  <= (phase_next_d == S_DONE);
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Phase outputs decode straight from the registered state.
  always_comb begin
    sel      = 2'b11;
    ld_ready = 1'b0;
    sh_en    = 1'b0;
    wb_valid = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        sel      = 2'b00;
        ld_ready = 1'b1;
      end
      S_SHIFT: begin
        sel   = 2'b01;
        sh_en = 1'b1;
      end
      S_WB: begin
        sel      = 2'b10;
        wb_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer: directed scenarios plus random traffic,
// checked every cycle against a phase-queue reference model.
module tb_pe_sequencer;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] ld_len, sh_len, wb_len;
  logic             abort;
  logic             ld_valid;
  logic             ld_ready;
  logic             sh_en;
  logic             wb_valid;
  logic             wb_ready;
  logic [1:0]       sel;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: 0 load, 1 shift, 2 write-back, 3 idle, 4 done.
  int m_ph   = 3;
  int m_len  = 0;
  int m_left = 0;
  int q_ph[$];
  int q_len[$];

  pe_sequencer #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ld_len   (ld_len),
    .sh_len   (sh_len),
    .wb_len   (wb_len),
    .abort    (abort),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .sh_en    (sh_en),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .sel      (sel),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic advance();
    if (q_ph.size() == 0) begin
      m_ph = 4;
    end else begin
      m_ph   = q_ph.pop_front();
      m_len  = q_len.pop_front();
      m_left = m_len;
    end
  endtask

  task automatic model_step(input bit st, input logic [CNT_W-1:0] l, s, w,
                            input bit ab, input bit lv, input bit wr);
    if (ab) begin
      m_ph = 3;
    end else begin
      case (m_ph)
        3: if (st) begin
          q_ph.delete();
          q_len.delete();
          if (l != 0) begin q_ph.push_back(0); q_len.push_back(int'(l)); end
          if (s != 0) begin q_ph.push_back(1); q_len.push_back(int'(s)); end
          if (w != 0) begin q_ph.push_back(2); q_len.push_back(int'(w)); end
          advance();
        end
        0: if (lv) begin m_left--; if (m_left == 0) advance(); end
        1: begin m_left--; if (m_left == 0) advance(); end
        2: if (wr) begin m_left--; if (m_left == 0) advance(); end
        default: m_ph = 3;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [1:0] exp_sel;
    exp_sel = (m_ph < 3) ? 2'(m_ph) : 2'b11;
    chk("sel",      32'(sel),      32'(exp_sel));
    chk("busy",     32'(busy),     32'(m_ph != 3));
    chk("done",     32'(done),     32'(m_ph == 4));
    chk("ld_ready", 32'(ld_ready), 32'(m_ph == 0));
    chk("sh_en",    32'(sh_en),    32'(m_ph == 1));
    chk("wb_valid", 32'(wb_valid), 32'(m_ph == 2));
    if (m_ph < 3) chk("cnt", 32'(cnt), 32'(m_len - m_left));
  endtask

  // One clock cycle: drive at the falling edge, check state-derived outputs, advance model.
  task automatic cycle(input bit st, input logic [CNT_W-1:0] l, s, w,
                       input bit ab, input bit lv, input bit wr);
    @(negedge clk);
    start = st; ld_len = l; sh_len = s; wb_len = w;
    abort = ab; ld_valid = lv; wb_ready = wr;
    check_outputs();
    model_step(st, l, s, w, ab, lv, wr);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ld_len = '0; sh_len = '0; wb_len = '0;
    abort = 1'b0; ld_valid = 1'b0; wb_ready = 1'b0;
    #12;
    chk("rst_sel",  32'(sel),  32'h3);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_cnt",  32'(cnt),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();

    // Nominal 4/3/2 run with no stalls.
    for (int k = 0; k < 12; k++) begin
      cycle(k == 0, 8'd4, 8'd3, 8'd2, 1'b0, 1'b1, 1'b1);
      if (k == 10) chk("nominal_done_at_10", 32'(done), 32'h1);
      if (k == 11) chk("nominal_idle_at_11", 32'(busy), 32'h0);
    end

    // Backpressure on load and write-back.
    for (int k = 0; k < 12; k++) begin
      cycle(k == 0, 8'd2, 8'd1, 8'd1, 1'b0, (k == 1) || (k == 4), k >= 9);
      if (k == 10) chk("backpressure_done_at_10", 32'(done), 32'h1);
    end

    // Zero-length phases are skipped.
    for (int k = 0; k < 5; k++) begin
      cycle(k == 0, 8'd0, 8'd2, 8'd0, 1'b0, 1'b1, 1'b1);
      if (k == 3) chk("shift_only_done_at_3", 32'(done), 32'h1);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(k == 0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
      if (k == 1) chk("all_zero_done_at_1", 32'(done), 32'h1);
    end

    // Abort in the second load cycle, then a fresh run.
    for (int k = 0; k < 4; k++) begin
      cycle(k == 0, 8'd4, 8'd3, 8'd2, k == 2, 1'b1, 1'b1);
      if (k == 3) chk("abort_to_idle", 32'(busy), 32'h0);
    end
    for (int k = 0; k < 6; k++) begin
      cycle(k == 0, 8'd1, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1);
      if (k == 4) chk("after_abort_done", 32'(done), 32'h1);
    end

    // Abort together with start in IDLE keeps the sequencer idle.
    cycle(1'b1, 8'd3, 8'd3, 8'd3, 1'b1, 1'b1, 1'b1);
    idle_cycle();
    chk("abort_beats_start", 32'(busy), 32'h0);

    // Start during write-back is ignored.
    for (int k = 0; k < 11; k++) begin
      cycle((k == 0) || (k == 3), (k == 0) ? 8'd1 : 8'd5, (k == 0) ? 8'd1 : 8'd5,
            (k == 0) ? 8'd3 : 8'd5, 1'b0, 1'b1, 1'b1);
      if (k == 6) chk("ignored_start_done", 32'(done), 32'h1);
      if (k == 10) chk("ignored_start_no_rerun", 32'(busy), 32'h0);
    end

    // Full-scale shift length.
    for (int k = 0; k < 258; k++) begin
      cycle(k == 0, 8'd0, 8'd255, 8'd0, 1'b0, 1'b1, 1'b1);
      if (k == 255) chk("max_len_last_cnt", 32'(cnt), 32'd254);
      if (k == 256) chk("max_len_done", 32'(done), 32'h1);
    end

    // Asynchronous reset while in SHIFT.
    cycle(1'b1, 8'd0, 8'd6, 8'd0, 1'b0, 1'b1, 1'b1);
    idle_cycle();
    idle_cycle();
    @(negedge clk);
    chk("pre_rst_in_shift", 32'(sel), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_sel",  32'(sel),  32'h3);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_cnt",  32'(cnt),  32'h0);
    m_ph = 3;
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 5) == 0,
            8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
            $urandom_range(0, 59) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
